// File: rtl/angle_sort_n.sv
// Serial-load angular sorter: point 0 is the pivot, points 1..N_PTS-1 are
// bubble-sorted by cross-product sign about it, then streamed out in order.
module angle_sort_n #(
  parameter int N_PTS = 6,
  parameter int CW    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*CW-1:0] in_pt,
  input  logic            dir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*CW-1:0] out_pt,
  output logic            out_last,
  output logic            busy
);

  localparam int IW = $clog2(N_PTS);
  localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);
  localparam logic [IW-1:0] JEND = IW'(N_PTS - 2);
  localparam logic [IW-1:0] PEND = IW'(N_PTS - 3);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ld_cnt, j, pass, out_cnt;
  logic            dir_q, swap_flag;
  logic [2*CW-1:0] pts [N_PTS];

  logic [2*CW-1:0]       pt_p, pt_a, pt_b;
  logic signed [CW:0]    dax, day, dbx, dby;
  logic signed [2*CW+2:0] cr;
  logic                  keep, swap, sort_done;

  assign pt_p = pts[0];
  assign pt_a = pts[j];
  assign pt_b = pts[j + ONE];

  // Zero-extend before subtracting so the differences are exact signed values.
  assign dax = $signed({1'b0, pt_a[2*CW-1:CW]}) - $signed({1'b0, pt_p[2*CW-1:CW]});
  assign day = $signed({1'b0, pt_a[CW-1:0]})    - $signed({1'b0, pt_p[CW-1:0]});
  assign dbx = $signed({1'b0, pt_b[2*CW-1:CW]}) - $signed({1'b0, pt_p[2*CW-1:CW]});
  assign dby = $signed({1'b0, pt_b[CW-1:0]})    - $signed({1'b0, pt_p[CW-1:0]});
  assign cr  = dax * dby - day * dbx;

  assign keep      = dir_q ? !cr[2*CW+2] : (cr[2*CW+2] || (cr == '0));
  assign swap      = (state == SORT) && !keep;
  assign sort_done = (j == JEND) && (!(swap_flag || swap) || (pass == PEND));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: if (in_valid && (ld_cnt == LAST))   state_nx = SORT;
      SORT: if (sort_done)                      state_nx = OUT;
      OUT:  if (out_ready && (out_cnt == LAST)) state_nx = LOAD;
      default:                                  state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt    <= '0;
      j         <= '0;
      pass      <= '0;
      out_cnt   <= '0;
      dir_q     <= 1'b0;
      swap_flag <= 1'b0;
    end else begin
      unique case (state)
        LOAD: if (in_valid) begin
          if (ld_cnt == '0) dir_q <= dir;
          if (ld_cnt == LAST) begin
            ld_cnt    <= '0;
            j         <= ONE;
            pass      <= '0;
            swap_flag <= 1'b0;
          end else begin
            ld_cnt <= ld_cnt + ONE;
          end
        end
        SORT: begin
          if (j == JEND) begin
            if (!sort_done) begin
              j         <= ONE;
              pass      <= pass + ONE;
              swap_flag <= 1'b0;
            end else begin
              out_cnt <= '0;
            end
          end else begin
            j         <= j + ONE;
            swap_flag <= swap_flag || swap;
          end
        end
        OUT: if (out_ready) begin
          if (out_cnt == LAST) out_cnt <= '0;
          else                 out_cnt <= out_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  // Point storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_valid) begin
      pts[ld_cnt] <= in_pt;
    end else if (swap) begin
      pts[j]       <= pt_b;
      pts[j + ONE] <= pt_a;
    end
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == OUT);
  assign out_last  = (state == OUT) && (out_cnt == LAST);
  assign out_pt    = (state == OUT) ? pts[out_cnt] : '0;

endmodule

// File: tb/tb_angle_sort_n.sv
// Self-checking bench for angle_sort_n: directed table, corner sequences and
// randomized point sets checked against a stable angular insertion-sort model.
module tb_angle_sort_n;

  localparam int N  = 6;
  localparam int CW = 10;

  typedef logic [N-1:0][2*CW-1:0] pts_t;
  typedef struct packed {
    logic       d;
    pts_t       pin;
    pts_t       pexp;
    logic [7:0] cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, dir, out_valid, out_ready, out_last, busy;
  logic [2*CW-1:0] in_pt, out_pt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  angle_sort_n #(.N_PTS(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_pt(out_pt), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [2*CW-1:0] mk(input int x, input int y);
    return {x[CW-1:0], y[CW-1:0]};
  endfunction

  function automatic pts_t pk(input logic [2*CW-1:0] v0, v1, v2, v3, v4, v5);
    pts_t r;
    r[0] = v0; r[1] = v1; r[2] = v2; r[3] = v3; r[4] = v4; r[5] = v5;
    return r;
  endfunction

  function automatic int xof(input logic [2*CW-1:0] v);
    return int'(v[2*CW-1:CW]);
  endfunction

  function automatic int yof(input logic [2*CW-1:0] v);
    return int'(v[CW-1:0]);
  endfunction

  // u strictly precedes v in the requested rotational order about the pivot
  function automatic bit precedes(input pts_t p, input logic d, input int u, input int v);
    longint c;
    c = longint'(xof(p[u]) - xof(p[0])) * longint'(yof(p[v]) - yof(p[0]))
      - longint'(yof(p[u]) - yof(p[0])) * longint'(xof(p[v]) - xof(p[0]));
    return d ? (c > 0) : (c < 0);
  endfunction

  function automatic pts_t ref_sort(input pts_t p, input logic d);
    int   q[$];
    int   pos;
    pts_t r;
    for (int i = 1; i < N; i++) begin
      pos = q.size();
      while (pos > 0 && precedes(p, d, i, q[pos-1])) pos--;
      q.insert(pos, i);
    end
    r[0] = p[0];
    for (int k = 1; k < N; k++) r[k] = p[q[k-1]];
    return r;
  endfunction

  // Entered at a falling edge; leaves at the falling edge inside SORT cycle 1.
  task automatic load_pts(input pts_t pin, input logic d, input int gap);
    for (int i = 0; i < N; i++) begin
      if (gap > 0 && i > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_pt    = pin[i];
      dir      = (i == 0) ? d : 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    dir      = ~d;
  endtask

  task automatic run_case(input string tag, input pts_t pin, input logic d,
                          input pts_t pexp, input int exp_cyc, input int gap,
                          input int stall_at);
    int cyc;
    load_pts(pin, d, gap);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) cyc++;
      @(negedge clk);
    end
    chk({tag, "_out_reached"}, out_valid, 1);
    if (exp_cyc >= 0) chk({tag, "_sort_cycles"}, cyc, exp_cyc);
    else chk({tag, "_sort_cycles_in_bounds"}, (cyc >= N-2 && cyc <= (N-2)*(N-2)), 1);
    for (int k = 0; k < N; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("%s_stall_valid%0d", tag, k), out_valid, 1);
          chk($sformatf("%s_stall_pt%0d", tag, k), out_pt, pexp[k]);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s_valid%0d", tag, k), out_valid, 1);
      chk($sformatf("%s_pt%0d", tag, k), out_pt, pexp[k]);
      chk($sformatf("%s_last%0d", tag, k), out_last, (k == N-1));
      @(negedge clk);
    end
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2*CW-1:0] P, A, B, C, D, E, F1, F2;
    vec_t vecs[4];
    pts_t rp;
    logic rd;
    int   px, py;

    P  = mk(20, 10);  A = mk(60, 10);  B = mk(60, 50);
    C  = mk(20, 50);  D = mk(0, 40);   E = mk(0, 15);
    F1 = mk(100, 10); F2 = mk(60, 10);

    vecs[0] = '{d: 1'b1, pin: pk(P, A, B, C, D, E), pexp: pk(P, A, B, C, D, E), cyc: 8'd4};
    vecs[1] = '{d: 1'b1, pin: pk(P, E, D, C, B, A), pexp: pk(P, A, B, C, D, E), cyc: 8'd16};
    vecs[2] = '{d: 1'b0, pin: pk(P, A, B, C, D, E), pexp: pk(P, E, D, C, B, A), cyc: 8'd16};
    vecs[3] = '{d: 1'b1, pin: pk(P, F1, F2, B, C, D), pexp: pk(P, F1, F2, B, C, D), cyc: 8'd4};

    reset = 1'b1; in_valid = 1'b0; in_pt = '0; dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_pt", out_pt, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++)
      run_case($sformatf("vec%0d", v), vecs[v].pin, vecs[v].d, vecs[v].pexp,
               int'(vecs[v].cyc), 0, -1);

    run_case("backpressure", vecs[0].pin, 1'b1, vecs[0].pexp, 4, 0, 2);
    run_case("gapped", vecs[0].pin, 1'b1, vecs[0].pexp, 4, 1, -1);

    load_pts(vecs[1].pin, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("midsort_busy", busy, 1);
    chk("midsort_out_valid", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_case("after_abort", vecs[1].pin, 1'b1, vecs[1].pexp, 16, 0, -1);

    for (int r = 0; r < 20; r++) begin
      px = int'($urandom_range(0, 1023));
      py = int'($urandom_range(0, 400));
      rp[0] = mk(px, py);
      for (int i = 1; i < N; i++)
        rp[i] = mk(int'($urandom_range(0, 1023)), int'($urandom_range(py + 1, 1023)));
      rd = 1'($urandom);
      run_case($sformatf("rand%0d", r), rp, rd, ref_sort(rp, rd), -1, r % 2,
               (r % 3 == 0) ? int'($urandom_range(0, N-1)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
